// File: rtl/mul_div_unit.sv
// -----------------------------------------------------------------------------
// mul_div_unit
//   Iterative RV32M multiply/divide unit used beside the single-cycle ALU in
//   the multicycle datapath. One operation is accepted through a valid/ready
//   handshake. The unit then works one bit per cycle on operand magnitudes,
//   applies sign correction in a single fix-up cycle, and holds the result
//   until the consumer takes it.
//
// Parameters
//   N           operand/result width (>= 4)
//
// Ports
//   clk         clock, rising edge
//   rst         asynchronous, active-high reset
//   in_valid    operation request
//   in_ready    unit can accept a request (IDLE only)
//   opc         000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//               100 DIV, 101 DIVU, 110 REM, 111 REMU
//   lhs, rhs    operands (MULHSU: lhs signed, rhs unsigned)
//   out_valid   res/zero/neg valid; held until out_ready
//   out_ready   consumer takes the result
//   res         result
//   zero, neg   ~|res and res[N-1]
//   busy        high in CALC/FIX/DONE
//
// Build option
//   MDU_EARLY_OUT_EN  when defined, divide-by-zero, signed overflow, lhs==0 and
//                     rhs==0 for multiplies bypass CALC (IDLE -> FIX). Results
//                     are identical to the full-latency path.
//
// States
//   S_IDLE | waiting for in_valid; operands captured on accept
//   S_CALC | N iterations, one bit per cycle on magnitudes
//   S_FIX  | sign correction and result select (one cycle)
//   S_DONE | result presented until out_ready
// -----------------------------------------------------------------------------
module mul_div_unit #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   opc,
  input  logic [N-1:0] lhs,
  input  logic [N-1:0] rhs,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] res,
  output logic         zero,
  output logic         neg,
  output logic         busy
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [2:0]     opc_q, opc_d;
  // Multiplicand for MUL*, divisor for DIV*/REM*.
  logic [N-1:0]   m_q, m_d;
  // MUL*: {partial product high, multiplier/product low}
  // DIV*: {partial remainder, dividend/quotient}
  logic [2*N-1:0] acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           a_neg_q, a_neg_d;
  logic           sgn_q, sgn_d;
  logic           div0_q, div0_d;
  logic [N-1:0]   res_q, res_d;

  // ---------------------------------------------------------------------------
  // Operand decode on the request side
  // ---------------------------------------------------------------------------
  logic         signed_a, signed_b;
  logic         in_a_neg, in_b_neg;
  logic [N-1:0] in_a_mag, in_b_mag;

  always_comb begin
    signed_a = opc[2] ? ~opc[0] : (opc != 3'b011);
    signed_b = opc[2] ? ~opc[0] : ~opc[1];
    in_a_neg = signed_a & lhs[N-1];
    in_b_neg = signed_b & rhs[N-1];
    // The most-negative value maps onto itself, which read unsigned is its
    // magnitude, so no extra bit is needed.
    in_a_mag = in_a_neg ? -lhs : lhs;
    in_b_mag = in_b_neg ? -rhs : rhs;
  end

`ifdef MDU_EARLY_OUT_EN
  logic           early_div0, early_ovf, early_take;
  logic [2*N-1:0] early_acc;

  assign early_div0 = opc[2] && (rhs == '0);
  assign early_ovf  = opc[2] && !opc[0] && (lhs == {1'b1, {(N-1){1'b0}}}) && (rhs == '1);
  assign early_take = (lhs == '0) || early_div0 || early_ovf || (!opc[2] && (rhs == '0));

  // Preload the accumulator with what CALC would have produced, so FIX is
  // shared with the full-latency path: div0 -> remainder |lhs|, quotient is
  // forced in FIX; overflow -> quotient |lhs|, remainder 0; otherwise all zero.
  assign early_acc = early_div0 ? {in_a_mag, {N{1'b0}}} :
                     early_ovf  ? {{N{1'b0}}, in_a_mag} : '0;
`endif

  // ---------------------------------------------------------------------------
  // One iteration of shift-add multiply and restoring divide
  // ---------------------------------------------------------------------------
  logic [N:0]   mul_sum;
  logic [N:0]   div_r;
  logic [N-1:0] div_trial;
  logic [N-1:0] div_rem;
  logic         div_ge;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, m_q} : '0);
    div_r     = acc_q[2*N-1:N-1];
    div_ge    = (div_r >= {1'b0, m_q});
    // When div_ge holds the true difference is below 2^N, so the low N bits
    // of the subtraction are exact.
    div_trial = div_r[N-1:0] - m_q;
    div_rem   = div_ge ? div_trial : div_r[N-1:0];
  end

  // ---------------------------------------------------------------------------
  // Sign correction
  // ---------------------------------------------------------------------------
  logic [2*N-1:0] prod_fix;
  logic [N-1:0]   quo_fix;
  logic [N-1:0]   rem_fix;

  always_comb begin
    prod_fix = sgn_q ? -acc_q : acc_q;
    // Divide by zero returns all ones for signed and unsigned alike, so the
    // quotient sign flip must not apply there.
    quo_fix  = div0_q ? '1 : (sgn_q ? -acc_q[N-1:0] : acc_q[N-1:0]);
    rem_fix  = a_neg_q ? -acc_q[2*N-1:N] : acc_q[2*N-1:N];
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath control
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    m_d     = m_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    a_neg_d = a_neg_q;
    sgn_d   = sgn_q;
    div0_d  = div0_q;
    res_d   = res_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          opc_d   = opc;
          a_neg_d = in_a_neg;
          sgn_d   = in_a_neg ^ in_b_neg;
          div0_d  = opc[2] && (rhs == '0);
          cnt_d   = CW'(N - 1);
          if (opc[2]) begin
            m_d   = in_b_mag;
            acc_d = {{N{1'b0}}, in_a_mag};
          end else begin
            m_d   = in_a_mag;
            acc_d = {{N{1'b0}}, in_b_mag};
          end
          state_d = S_CALC;
`ifdef MDU_EARLY_OUT_EN
          if (early_take) begin
            acc_d   = early_acc;
            state_d = S_FIX;
          end
`endif
        end
      end

      S_CALC: begin
        if (opc_q[2]) begin
          acc_d = {div_rem, acc_q[N-2:0], div_ge};
        end else begin
          acc_d = {mul_sum, acc_q[N-1:1]};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        case (opc_q)
          3'b000:                res_d = prod_fix[N-1:0];
          3'b001, 3'b010, 3'b011: res_d = prod_fix[2*N-1:N];
          3'b100, 3'b101:        res_d = quo_fix;
          default:               res_d = rem_fix;
        endcase
        state_d = S_DONE;
      end

      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      opc_q   <= '0;
      m_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      a_neg_q <= 1'b0;
      sgn_q   <= 1'b0;
      div0_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      a_neg_q <= a_neg_d;
      sgn_q   <= sgn_d;
      div0_q  <= div0_d;
      res_q   <= res_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign res       = res_q;
  assign zero      = ~|res_q;
  assign neg       = res_q[N-1];

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;
  localparam int N = 32;
`ifdef MDU_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   opc;
  logic [N-1:0] lhs;
  logic [N-1:0] rhs;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] res;
  logic         zero;
  logic         neg;
  logic         busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [N-1:0] res;
    int           lat;
  } exp_t;

  exp_t sb[$];

  mul_div_unit #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opc       (opc),
    .lhs       (lhs),
    .rhs       (rhs),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .zero      (zero),
    .neg       (neg),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference result from 64-bit arithmetic plus the RV32M special cases.
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0]        sa, sb64, ua, ub, p;
    logic signed [31:0] q;
    sa   = {{32{a[31]}}, a};
    sb64 = {{32{b[31]}}, b};
    ua   = {32'd0, a};
    ub   = {32'd0, b};
    case (o)
      3'd0: begin p = sa * sb64; return p[31:0];  end
      3'd1: begin p = sa * sb64; return p[63:32]; end
      3'd2: begin p = sa * ub;   return p[63:32]; end
      3'd3: begin p = ua * ub;   return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        q = $signed(a) / $signed(b);
        return q;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        q = $signed(a) % $signed(b);
        return q;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    bit special;
    if (o[2]) special = (b == 0) || (a == 0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    else      special = (a == 0) || (b == 0);
    return (EARLY && special) ? 2 : N + 2;
  endfunction

  // Issue one operation (out_ready assumed 1), push its expectation, and
  // return what the DUT presented plus the observed latency.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] x,
                        output logic [31:0] r, output logic z, output logic ng, output int lat);
    exp_t e;
    int   n;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    opc = o; lhs = a; rhs = b; in_valid = 1'b1;
    e.res = x; e.lat = exp_lat(o, a, b);
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lhs = $urandom; rhs = $urandom; opc = 3'($urandom_range(0, 7));
    lat = 0;
    do begin @(negedge clk); lat++; end while (!out_valid && lat < 100);
    r = res; z = zero; ng = neg;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; opc = '0; lhs = '0; rhs = '0;
    repeat (2) @(negedge clk);
    total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (res !== '0)         begin bad++; $display("FAIL reset_res got=%h want=0", res); end
    rst = 1'b0;
  endtask

  task automatic test_mul();
    logic [2:0]  o[8];
    logic [31:0] a[8], b[8], x[8];
    logic [31:0] r; logic z, ng; int lat; exp_t e;
    o = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd0, 3'd1, 3'd2, 3'd3};
    a = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678, 32'hFFFF_FFFB, 32'h7FFF_FFFF, 32'hDEAD_BEEF};
    b = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2, 32'h9ABC_DEF0, 32'd3, 32'hFFFF_FFFF, 32'h0BAD_F00D};
    x = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0};
    for (int i = 4; i < 8; i++) x[i] = model(o[i], a[i], b[i]);
    for (int i = 0; i < 8; i++) begin
      run_op(o[i], a[i], b[i], x[i], r, z, ng, lat);
      e = sb.pop_front();
      total++; if (r !== e.res)          begin bad++; $display("FAIL mul_res[%0d] got=%h want=%h", i, r, e.res); end
      total++; if (lat !== e.lat)        begin bad++; $display("FAIL mul_lat[%0d] got=%0d want=%0d", i, lat, e.lat); end
      total++; if (ng !== e.res[31])     begin bad++; $display("FAIL mul_neg[%0d] got=%b want=%b", i, ng, e.res[31]); end
      total++; if (z !== (e.res == 0))   begin bad++; $display("FAIL mul_zero[%0d] got=%b want=%b", i, z, (e.res == 0)); end
    end
  endtask

  task automatic test_div();
    logic [2:0]  o[8];
    logic [31:0] a[8], b[8], x[8];
    logic [31:0] r; logic z, ng; int lat; exp_t e;
    o = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd5, 3'd7};
    a = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'h8765_4321, 32'h7654_3210, 32'hFEDC_BA98, 32'h0000_FFFF};
    b = '{32'd2, 32'd2, 32'd7, 32'd7, 32'h0000_1234, 32'hFFFF_FF00, 32'h0000_0013, 32'h0000_0100};
    x = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2, 32'h0, 32'h0, 32'h0, 32'h0};
    for (int i = 4; i < 8; i++) x[i] = model(o[i], a[i], b[i]);
    for (int i = 0; i < 8; i++) begin
      run_op(o[i], a[i], b[i], x[i], r, z, ng, lat);
      e = sb.pop_front();
      total++; if (r !== e.res)        begin bad++; $display("FAIL div_res[%0d] got=%h want=%h", i, r, e.res); end
      total++; if (lat !== e.lat)      begin bad++; $display("FAIL div_lat[%0d] got=%0d want=%0d", i, lat, e.lat); end
      total++; if (z !== (e.res == 0)) begin bad++; $display("FAIL div_zero[%0d] got=%b want=%b", i, z, (e.res == 0)); end
    end
  endtask

  task automatic test_special();
    logic [2:0]  o[8];
    logic [31:0] a[8], b[8], x[8];
    logic [31:0] r; logic z, ng; int lat; exp_t e;
    o = '{3'd5, 3'd6, 3'd4, 3'd6, 3'd4, 3'd0, 3'd3, 3'd7};
    a = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF9, 32'd0, 32'd1234, 32'hFFFF_FFF9};
    b = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1234, 32'd0, 32'd0};
    x = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'hFFFF_FFF9};
    for (int i = 0; i < 8; i++) begin
      run_op(o[i], a[i], b[i], x[i], r, z, ng, lat);
      e = sb.pop_front();
      total++; if (r !== e.res)        begin bad++; $display("FAIL special_res[%0d] got=%h want=%h", i, r, e.res); end
      total++; if (lat !== e.lat)      begin bad++; $display("FAIL special_lat[%0d] got=%0d want=%0d", i, lat, e.lat); end
      total++; if (z !== (e.res == 0)) begin bad++; $display("FAIL special_zero[%0d] got=%b want=%b", i, z, (e.res == 0)); end
    end
  endtask

  task automatic test_random();
    logic [2:0] o; logic [31:0] a, b, r; logic z, ng; int lat; exp_t e;
    for (int i = 0; i < 10; i++) begin
      o = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
      if (i == 3) b = 32'd1;
      run_op(o, a, b, model(o, a, b), r, z, ng, lat);
      e = sb.pop_front();
      total++; if (r !== e.res)   begin bad++; $display("FAIL rand_res[%0d] opc=%0d a=%h b=%h got=%h want=%h", i, o, a, b, r, e.res); end
      total++; if (lat !== e.lat) begin bad++; $display("FAIL rand_lat[%0d] got=%0d want=%0d", i, lat, e.lat); end
    end
  endtask

  task automatic test_backpressure();
    exp_t e, e2; int n;
    out_ready = 1'b0;
    @(negedge clk);
    opc = 3'd5; lhs = 32'd100; rhs = 32'd7; in_valid = 1'b1;
    e.res = 32'd14; e.lat = exp_lat(3'd5, 32'd100, 32'd7);
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 100);
    e = sb.pop_front();
    total++; if (n !== e.lat) begin bad++; $display("FAIL bp_lat got=%0d want=%0d", n, e.lat); end
    opc = 3'd0; lhs = 32'd3; rhs = 32'd4; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || res !== e.res) begin
        bad++; $display("FAIL bp_hold[%0d] out_valid=%b in_ready=%b res=%h want 1/0/%h", k, out_valid, in_ready, res, e.res);
      end
    end
    out_ready = 1'b1;
    e2.res = 32'd12; e2.lat = exp_lat(3'd0, 32'd3, 32'd4);
    sb.push_back(e2);
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL bp_handoff busy=%b in_ready=%b out_valid=%b want 0/1/0", busy, in_ready, out_valid);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 100);
    e2 = sb.pop_front();
    total++; if (n !== e2.lat)   begin bad++; $display("FAIL bp_second_lat got=%0d want=%0d", n, e2.lat); end
    total++; if (res !== e2.res) begin bad++; $display("FAIL bp_second_res got=%h want=%h", res, e2.res); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [2:0]  o[3];
    logic [31:0] a[3], b[3];
    exp_t e; int n;
    o = '{3'd5, 3'd1, 3'd7};
    a = '{32'd1000, 32'h7FFF_FFFF, 32'd1000};
    b = '{32'd10, 32'h7FFF_FFFF, 32'd7};
    out_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      opc = o[i]; lhs = a[i]; rhs = b[i]; in_valid = 1'b1;
      e.res = model(o[i], a[i], b[i]); e.lat = exp_lat(o[i], a[i], b[i]);
      sb.push_back(e);
      @(negedge clk);
      if (i > 0) begin
        total++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
          bad++; $display("FAIL b2b_gap[%0d] busy=%b in_ready=%b want 0/1", i, busy, in_ready);
        end
        @(negedge clk);
      end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept[%0d] busy=%b want=1", i, busy); end
      n = 0;
      while (!out_valid && n < 100) begin @(negedge clk); n++; end
      e = sb.pop_front();
      total++; if (res !== e.res) begin bad++; $display("FAIL b2b_res[%0d] got=%h want=%h", i, res, e.res); end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midop();
    logic [31:0] r; logic z, ng; int lat; exp_t e;
    @(negedge clk);
    opc = 3'd4; lhs = 32'hFFFF_FF9C; rhs = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL midrst_in_ready got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid got=%b want=0", out_valid); end
    total++; if (res !== '0)         begin bad++; $display("FAIL midrst_res got=%h want=0", res); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
    @(negedge clk);
    rst = 1'b0;
    run_op(3'd0, 32'd3, 32'd4, 32'd12, r, z, ng, lat);
    e = sb.pop_front();
    total++; if (r !== e.res)   begin bad++; $display("FAIL midrst_mul_res got=%h want=%h", r, e.res); end
    total++; if (lat !== e.lat) begin bad++; $display("FAIL midrst_mul_lat got=%0d want=%0d", lat, e.lat); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_random();
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
    total++; if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_left got=%0d want=0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
